// File: rtl/load_store_unit.sv
// Load/store unit: moves data between the accumulator and DataMemory using
// direct or pointer-indirect addressing, one operation at a time.
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nReset,
    input  logic                  Start,
    input  logic [1:0]            Op,
    input  logic [DATA_WIDTH-1:0] Operand,
    input  logic                  AccuWrEn,
    input  logic [DATA_WIDTH-1:0] AccuWrData,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic [DATA_WIDTH-1:0] Accu,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic                  MemWE,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              op_q;
    logic [1:0]              op_nxt;
    logic [DATA_WIDTH-1:0]   operand_q;
    logic [DATA_WIDTH-1:0]   operand_nxt;
    logic [DATA_WIDTH-1:0]   ptr_q;
    logic [DATA_WIDTH-1:0]   ptr_nxt;
    logic [DATA_WIDTH-1:0]   accu_nxt;
    logic [DATA_WIDTH-1:0]   addr_nxt;
    logic                    we_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;

    // Next-state and next-output decode; outputs are computed for the state
    // being entered so that every port comes straight from a flop.
    always_comb begin
        state_nxt   = state;
        op_nxt      = op_q;
        operand_nxt = operand_q;
        ptr_nxt     = ptr_q;
        accu_nxt    = Accu;
        addr_nxt    = '0;
        we_nxt      = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (AccuWrEn) begin
                    accu_nxt = AccuWrData;
                end
                if (Start) begin
                    op_nxt      = Op;
                    operand_nxt = Operand;
                    addr_nxt    = Operand;
                    if (Op[1]) begin
                        state_nxt = PTR;
                    end else begin
                        state_nxt = ACCESS;
                        we_nxt    = Op[0];
                    end
                end
            end
            PTR: begin
                ptr_nxt   = MemData;
                addr_nxt  = ptr_nxt;
                we_nxt    = op_q[0];
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!op_q[0]) begin
                    accu_nxt = MemData;
                end
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset abandons any op immediately.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            op_q      <= '0;
            operand_q <= '0;
            ptr_q     <= '0;
            Accu      <= '0;
            MemAddr   <= '0;
            MemWE     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            operand_q <= operand_nxt;
            ptr_q     <= ptr_nxt;
            Accu      <= accu_nxt;
            MemAddr   <= addr_nxt;
            MemWE     <= we_nxt;
            Busy      <= busy_nxt;
            Done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of operations against a DataMemory model,
// plus hand sequences for reset behaviour.
module tb_load_store_unit;

    logic       clk;
    logic       nReset;
    logic       Start;
    logic [1:0] Op;
    logic [7:0] Operand;
    logic       AccuWrEn;
    logic [7:0] AccuWrData;
    logic [7:0] MemData;
    logic [7:0] Accu;
    logic [7:0] MemAddr;
    logic       MemWE;
    logic       Busy;
    logic       Done;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .Start      (Start),
        .Op         (Op),
        .Operand    (Operand),
        .AccuWrEn   (AccuWrEn),
        .AccuWrData (AccuWrData),
        .MemData    (MemData),
        .Accu       (Accu),
        .MemAddr    (MemAddr),
        .MemWE      (MemWE),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory: reset contents mem[i] = i, write on rising edge, reads 0 while writing.
    logic [7:0] mem [256];
    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (MemWE) begin
            mem[MemAddr] <= Accu;
        end
    end
    assign MemData = MemWE ? 8'h00 : mem[MemAddr];

    typedef struct {
        logic [1:0] op;
        logic [7:0] operand;
        int         wr_mode;   // 0 none, 1 write cycle before Start, 2 write with Start
        logic [7:0] wr_data;
        logic       hold;      // keep Start/AccuWrEn(0x33) asserted while busy
        logic [7:0] exp_accu;
        int         exp_lat;
        int         exp_we;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t tbl [14];
    vec_t sb [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation; caller is positioned just after a falling edge.
    task automatic run_op(input vec_t v, input string tag);
        vec_t e;
        int   lat;
        int   we_cnt;
        int   done_cnt;
        logic [7:0] acc_addr;
        logic [7:0] acc_accu;
        logic [7:0] ptr_addr;
        logic       ptr_we;
        lat = 0; we_cnt = 0; done_cnt = 0;
        acc_addr = '0; acc_accu = '0; ptr_addr = '0; ptr_we = 1'b0;
        if (v.wr_mode == 1) begin
            AccuWrEn = 1'b1; AccuWrData = v.wr_data;
            @(negedge clk);
            AccuWrEn = 1'b0;
        end
        Start = 1'b1; Op = v.op; Operand = v.operand;
        AccuWrEn = (v.wr_mode == 2); AccuWrData = v.wr_data;
        sb.push_back(v);
        for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
            @(negedge clk);
            if (v.hold) begin
                Start = 1'b1; AccuWrEn = 1'b1; AccuWrData = 8'h33;
            end else begin
                Start = 1'b0; AccuWrEn = 1'b0;
            end
            if (MemWE) we_cnt++;
            if (cyc == 1) begin
                ptr_addr = MemAddr; ptr_we = MemWE;
            end
            if (cyc == v.exp_lat - 1) begin
                acc_addr = MemAddr; acc_accu = Accu;
            end
            if (Done) begin
                lat = cyc; done_cnt++;
                Start = 1'b0; AccuWrEn = 1'b0;
            end
        end
        e = sb.pop_front();
        if (lat == 0) begin
            check({tag, " done_timeout"}, 0, 1);
            return;
        end
        check({tag, " latency"}, lat, e.exp_lat);
        check({tag, " accu"}, int'(Accu), int'(e.exp_accu));
        check({tag, " addr_done"}, int'(MemAddr), 0);
        check({tag, " we_cycles"}, we_cnt, e.exp_we);
        check({tag, " access_addr"}, int'(acc_addr), int'(e.exp_addr));
        if (e.op[0]) check({tag, " store_accu"}, int'(acc_accu), int'(e.exp_accu));
        if (e.op[1]) begin
            check({tag, " ptr_addr"}, int'(ptr_addr), int'(e.operand));
            check({tag, " ptr_we"}, int'(ptr_we), 0);
        end
        @(negedge clk);
        if (Done) done_cnt++;
        check({tag, " busy_after"}, int'(Busy), 0);
        check({tag, " done_pulses"}, done_cnt, 1);
    endtask

    initial begin
        vec_t v;
        int   dcnt;
        tbl[0]  = '{2'b00, 8'h05, 0, 8'h00, 1'b0, 8'h05, 2, 0, 8'h05};
        tbl[1]  = '{2'b01, 8'h10, 1, 8'hA5, 1'b0, 8'hA5, 2, 1, 8'h10};
        tbl[2]  = '{2'b00, 8'h10, 0, 8'h00, 1'b0, 8'hA5, 2, 0, 8'h10};
        tbl[3]  = '{2'b01, 8'h03, 1, 8'h80, 1'b0, 8'h80, 2, 1, 8'h03};
        tbl[4]  = '{2'b01, 8'h80, 1, 8'h5A, 1'b1, 8'h5A, 2, 1, 8'h80};
        tbl[5]  = '{2'b00, 8'h00, 0, 8'h00, 1'b0, 8'h00, 2, 0, 8'h00};
        tbl[6]  = '{2'b10, 8'h03, 0, 8'h00, 1'b1, 8'h5A, 3, 0, 8'h80};
        tbl[7]  = '{2'b01, 8'h20, 2, 8'h77, 1'b0, 8'h77, 2, 1, 8'h20};
        tbl[8]  = '{2'b00, 8'h20, 0, 8'h00, 1'b0, 8'h77, 2, 0, 8'h20};
        tbl[9]  = '{2'b11, 8'h03, 1, 8'h11, 1'b1, 8'h11, 3, 1, 8'h80};
        tbl[10] = '{2'b00, 8'h80, 0, 8'h00, 1'b0, 8'h11, 2, 0, 8'h80};
        tbl[11] = '{2'b10, 8'hFF, 0, 8'h00, 1'b0, 8'hFF, 3, 0, 8'hFF};
        tbl[12] = '{2'b11, 8'hFE, 2, 8'hC3, 1'b0, 8'hC3, 3, 1, 8'hFE};
        tbl[13] = '{2'b00, 8'hFE, 0, 8'h00, 1'b0, 8'hC3, 2, 0, 8'hFE};

        nReset = 1'b0; Start = 1'b0; Op = 2'b00; Operand = 8'h00;
        AccuWrEn = 1'b0; AccuWrData = 8'h00;
        repeat (3) @(negedge clk);
        check("rst accu", int'(Accu), 0);
        check("rst addr", int'(MemAddr), 0);
        check("rst we", int'(MemWE), 0);
        check("rst busy", int'(Busy), 0);
        check("rst done", int'(Done), 0);
        nReset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset during a STORE ACCESS: write strobe and state drop without a clock.
        AccuWrEn = 1'b1; AccuWrData = 8'h99;
        @(negedge clk);
        AccuWrEn = 1'b0;
        Start = 1'b1; Op = 2'b01; Operand = 8'h40;
        @(negedge clk);
        Start = 1'b0;
        check("midrst we_before", int'(MemWE), 1);
        #2 nReset = 1'b0;
        #1;
        check("midrst we", int'(MemWE), 0);
        check("midrst busy", int'(Busy), 0);
        check("midrst accu", int'(Accu), 0);
        check("midrst done", int'(Done), 0);
        dcnt = 0;
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (Done) dcnt++;
        end
        check("midrst no_done", dcnt, 0);

        // First Start right after reset release; aborted store must not have landed.
        nReset = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        v = '{2'b00, 8'h40, 0, 8'h00, 1'b0, 8'h40, 2, 0, 8'h40};
        run_op(v, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
